pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Multicycle control FSM that owns the program counter register's write port. It sequences each instruction through FETCH, EXECUTE and WRITEBACK, and selects the next PC: sequential, branch/jump target, or trap vector. It detects fetch and target misalignment, raises a trap, and halts on double fault or a halt request. It sits between the PC register, the instruction fetch port and the execute datapath.

Parameters:
TRAP_VECTOR, 32'h00000010, PC loaded on trap entry; bits [1:0] must be 2'b00.

Ports:
clock  in  1  system clock; all state changes on posedge
reset  in  1  asynchronous, active-low; asserted at 0
pcOfInstruction  in  32  current PC from the PC register
programCounterMisaligned  in  1  PC register's pc[1:0]!=0 flag
programCounterInput  out  32  next PC value to the PC register
programCounterWriteEnable  out  1  PC register load strobe
fetchRequest  out  1  instruction fetch request at pcOfInstruction
fetchReady  in  1  fetch data valid this cycle
instructionLatchEnable  out  1  one-cycle strobe that latches the fetched word
executeDone  in  1  execute datapath finished the current instruction
instructionIsJump  in  1  JAL/JALR
instructionIsBranch  in  1  conditional branch
branchTaken  in  1  branch condition true; valid with executeDone
targetAddress  in  32  jump/branch target; valid with executeDone
haltRequest  in  1  sampled with executeDone (EBREAK-style)
resume  in  1  leave a recoverable halt
writebackEnable  out  1  register-file commit strobe
trapActive  out  1  one-cycle strobe on trap entry
trapPc  out  32  PC of the faulting instruction; holds until the next trap
trapCause  out  2  00 none, 01 fetch misaligned, 10 target misaligned, 11 double fault
halted  out  1  FSM in HALT

Behaviour:
- States: IDLE, FETCH, EXECUTE, WRITEBACK, TRAP, HALT. Reset (reset=0) forces IDLE asynchronously, including mid-instruction.
- Reset values: all strobes 0, programCounterInput=0, trapPc=0, trapCause=00, halted=0, nextPc register=0, doubleFaultArm=0.
- IDLE: stays one cycle after reset deasserts, then goes to FETCH.
- FETCH, misaligned: if programCounterMisaligned=1, fetchRequest=0. Then:
  - doubleFaultArm=1 -> HALT with cause 11.
  - otherwise -> TRAP with cause 01, and trapPc=pcOfInstruction.
- FETCH, aligned: fetchRequest=1 until fetchReady. In the fetchReady cycle: instructionLatchEnable=1, doubleFaultArm cleared, -> EXECUTE. The FSM waits indefinitely for fetchReady.
- EXECUTE: waits for executeDone; it may already be asserted on the entry cycle. On executeDone:
  - taken = instructionIsJump | (instructionIsBranch & branchTaken).
  - nextPc = taken ? targetAddress : pcOfInstruction+4, modulo 2^32 (0xFFFFFFFC+4 = 0).
  - If taken and targetAddress[1:0]!=0 -> TRAP with cause 10 and trapPc=pcOfInstruction; no writeback.
  - Else if haltRequest -> HALT with nextPc registered and halted=1.
  - Else -> WRITEBACK with nextPc registered.
- WRITEBACK: one cycle. writebackEnable=1, programCounterWriteEnable=1, programCounterInput=nextPc. -> FETCH.
- TRAP: one cycle. programCounterWriteEnable=1, programCounterInput=TRAP_VECTOR, trapActive=1, doubleFaultArm set. -> FETCH.
- HALT: all strobes 0, halted=1.
  - Cause 11: only reset exits.
  - Otherwise resume=1 -> WRITEBACK, committing the halted instruction. resume is ignored in all other states.
- Simultaneous events: misalignment beats fetchReady in FETCH. Target-misaligned trap beats haltRequest.
- Latency (zero-wait fetch and execute): 3 cycles per instruction, 1 extra cycle per trap.
- Strobes are Moore outputs decoded from state. programCounterInput comes from a register. trapPc and trapCause are registered, updated only on trap entry, and cleared only by reset.

Decomposition:
- Shared core package holds:
  - state enum seq_state_t
  - trap cause enum trap_cause_t (NONE, FETCH_MISALIGNED, TARGET_MISALIGNED, DOUBLE_FAULT)
  - constant INSTRUCTION_BYTES=4
- One combinational sub-module, next_pc_select, computes nextPc, taken and targetMisaligned. The FSM stays in pc_sequencer.

Test Plan:
- Reset release, PC=0x00000000, fetchReady and executeDone tied 1, no branches -> PC write of 0x4 on cycle 4, then 0x8 three cycles later; writebackEnable pulses every 3 cycles.
- PC=0x00000100, branch taken to 0x00000040 -> programCounterInput=0x40 with WE=1 in WRITEBACK; a not-taken branch gives 0x104.
- PC=0xFFFFFFFC, sequential -> programCounterInput=0x00000000.
- PC=0x200, jump to 0x00000302 -> TRAP: trapCause=10, trapPc=0x200, PC written 0x10, no writebackEnable; the next fetch at 0x10 succeeds and clears doubleFaultArm.
- PC=0x0000000E misaligned -> trap cause 01. Then, with TRAP_VECTOR=0x12 in a separate instance, the fetch after trap is misaligned -> halted=1, cause 11, resume ignored, and only reset=0 clears it.
- haltRequest with executeDone at PC 0x20 -> halted=1 and no PC write. resume -> PC written 0x24. Asserting reset=0 mid-EXECUTE drops all strobes immediately.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the PC sequencer core.
package pc_sequencer_pkg;

   localparam int unsigned PC_W              = 32;
   localparam int unsigned INSTRUCTION_BYTES = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_EXECUTE,
      ST_WRITEBACK,
      ST_TRAP,
      ST_HALT
   } seq_state_t;

   typedef enum logic [1:0] {
      NONE              = 2'b00,
      FETCH_MISALIGNED  = 2'b01,
      TARGET_MISALIGNED = 2'b10,
      DOUBLE_FAULT      = 2'b11
   } trap_cause_t;

endpackage

// File: rtl/pc_sequencer_next_pc_select.sv
// Next-PC selection: sequential vs. branch/jump target, plus target alignment flag.
module next_pc_select
   import pc_sequencer_pkg::*;
(
   input  logic [PC_W-1:0] pcOfInstruction,
   input  logic            instructionIsJump,
   input  logic            instructionIsBranch,
   input  logic            branchTaken,
   input  logic [PC_W-1:0] targetAddress,
   output logic [PC_W-1:0] nextPc_c,
   output logic            taken_c,
   output logic            targetMisaligned_c
);

   assign taken_c            = instructionIsJump | (instructionIsBranch & branchTaken);
   assign targetMisaligned_c = |targetAddress[1:0];
   // Sequential increment wraps naturally at 2^32.
   assign nextPc_c           = taken_c ? targetAddress
                                       : pcOfInstruction + PC_W'(INSTRUCTION_BYTES);

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle PC sequencer: steps FETCH/EXECUTE/WRITEBACK, owns the PC write port,
// and handles misalignment traps, double faults and requested halts.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter logic [PC_W-1:0] TRAP_VECTOR = 32'h0000_0010
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [PC_W-1:0] pcOfInstruction,
   input  logic            programCounterMisaligned,
   output logic [PC_W-1:0] programCounterInput,
   output logic            programCounterWriteEnable,
   output logic            fetchRequest,
   input  logic            fetchReady,
   output logic            instructionLatchEnable,
   input  logic            executeDone,
   input  logic            instructionIsJump,
   input  logic            instructionIsBranch,
   input  logic            branchTaken,
   input  logic [PC_W-1:0] targetAddress,
   input  logic            haltRequest,
   input  logic            resume,
   output logic            writebackEnable,
   output logic            trapActive,
   output logic [PC_W-1:0] trapPc,
   output logic [1:0]      trapCause,
   output logic            halted
);

   seq_state_t      state_q, state_d;
   trap_cause_t     cause_q, cause_d;
   logic [PC_W-1:0] next_pc_q, next_pc_d;
   logic [PC_W-1:0] pc_in_q, pc_in_d;
   logic [PC_W-1:0] trap_pc_q, trap_pc_d;
   logic            arm_q, arm_d;
   logic            wb_q, pcwe_q, trap_q, halted_q;
   logic [PC_W-1:0] sel_pc;
   logic            sel_taken, sel_misaligned;

   next_pc_select u_next_pc_select (
      .pcOfInstruction    (pcOfInstruction),
      .instructionIsJump  (instructionIsJump),
      .instructionIsBranch(instructionIsBranch),
      .branchTaken        (branchTaken),
      .targetAddress      (targetAddress),
      .nextPc_c           (sel_pc),
      .taken_c            (sel_taken),
      .targetMisaligned_c (sel_misaligned)
   );

   // Next-state and next-register-value logic.
   always_comb begin
      state_d   = state_q;
      cause_d   = cause_q;
      next_pc_d = next_pc_q;
      pc_in_d   = pc_in_q;
      trap_pc_d = trap_pc_q;
      arm_d     = arm_q;
      case (state_q)
         ST_IDLE: state_d = ST_FETCH;
         ST_FETCH: begin
            if (programCounterMisaligned) begin
               trap_pc_d = pcOfInstruction;
               if (arm_q) begin
                  state_d = ST_HALT;
                  cause_d = DOUBLE_FAULT;
               end else begin
                  state_d = ST_TRAP;
                  cause_d = FETCH_MISALIGNED;
               end
            end else if (fetchReady) begin
               arm_d   = 1'b0;
               state_d = ST_EXECUTE;
            end
         end
         ST_EXECUTE: begin
            if (executeDone) begin
               if (sel_taken && sel_misaligned) begin
                  state_d   = ST_TRAP;
                  cause_d   = TARGET_MISALIGNED;
                  trap_pc_d = pcOfInstruction;
               end else begin
                  next_pc_d = sel_pc;
                  if (haltRequest) begin
                     state_d = ST_HALT;
                  end else begin
                     state_d = ST_WRITEBACK;
                     pc_in_d = sel_pc;
                  end
               end
            end
         end
         ST_WRITEBACK: state_d = ST_FETCH;
         ST_TRAP: begin
            arm_d   = 1'b1;
            state_d = ST_FETCH;
         end
         ST_HALT: begin
            // A double-fault halt is sticky; only reset leaves it.
            if (resume && (cause_q != DOUBLE_FAULT)) begin
               state_d = ST_WRITEBACK;
               pc_in_d = next_pc_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (state_d == ST_TRAP) pc_in_d = TRAP_VECTOR;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cause_q   <= NONE;
         next_pc_q <= '0;
         pc_in_q   <= '0;
         trap_pc_q <= '0;
         arm_q     <= 1'b0;
         wb_q      <= 1'b0;
         pcwe_q    <= 1'b0;
         trap_q    <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cause_q   <= cause_d;
         next_pc_q <= next_pc_d;
         pc_in_q   <= pc_in_d;
         trap_pc_q <= trap_pc_d;
         arm_q     <= arm_d;
         wb_q      <= (state_d == ST_WRITEBACK);
         pcwe_q    <= (state_d == ST_WRITEBACK) || (state_d == ST_TRAP);
         trap_q    <= (state_d == ST_TRAP);
         halted_q  <= (state_d == ST_HALT);
      end
   end

   // The fetch handshake follows the PC register's live alignment flag and fetchReady.
   assign fetchRequest              = (state_q == ST_FETCH) && !programCounterMisaligned;
   assign instructionLatchEnable    = fetchRequest && fetchReady;
   assign programCounterInput       = pc_in_q;
   assign programCounterWriteEnable = pcwe_q;
   assign writebackEnable           = wb_q;
   assign trapActive                = trap_q;
   assign trapPc                    = trap_pc_q;
   assign trapCause                 = cause_q;
   assign halted                    = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random instructions checked
// against per-instruction expectations computed from the sequencing rules.
`timescale 1ns/1ps
module tb_pc_sequencer;

   localparam logic [31:0] TV1 = 32'h0000_0010;
   localparam logic [31:0] TV2 = 32'h0000_0012;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset, fetchReady, executeDone, isJump, isBranch, brTaken, haltReq, resume;
   logic [31:0] target;
   logic        ovr;
   logic [31:0] ovr_val;
   logic [31:0] pc = '0;
   logic [31:0] pc2 = '0;

   logic [31:0] pcIn, trapPc, pcIn2, trapPc2;
   logic        pcWe, fetchReq, latchEn, wbEn, trapAct, halted;
   logic        pcWe2, fetchReq2, latchEn2, wbEn2, trapAct2, halted2;
   logic [1:0]  trapCause, trapCause2;

   int          vectors = 0;
   int          miscompares = 0;
   logic [1:0]  exp_cause;
   logic [31:0] exp_tpc;

   // PC registers around each sequencer; the second one comes out of reset misaligned.
   always @(posedge clock) begin
      if (ovr) pc <= ovr_val;
      else if (pcWe) pc <= pcIn;
      if (!reset) pc2 <= 32'h0000_000E;
      else if (pcWe2) pc2 <= pcIn2;
   end

   pc_sequencer #(.TRAP_VECTOR(TV1)) u_dut (
      .clock(clock), .reset(reset), .pcOfInstruction(pc),
      .programCounterMisaligned(|pc[1:0]), .programCounterInput(pcIn),
      .programCounterWriteEnable(pcWe), .fetchRequest(fetchReq), .fetchReady(fetchReady),
      .instructionLatchEnable(latchEn), .executeDone(executeDone),
      .instructionIsJump(isJump), .instructionIsBranch(isBranch), .branchTaken(brTaken),
      .targetAddress(target), .haltRequest(haltReq), .resume(resume),
      .writebackEnable(wbEn), .trapActive(trapAct), .trapPc(trapPc),
      .trapCause(trapCause), .halted(halted)
   );

   pc_sequencer #(.TRAP_VECTOR(TV2)) u_dut2 (
      .clock(clock), .reset(reset), .pcOfInstruction(pc2),
      .programCounterMisaligned(|pc2[1:0]), .programCounterInput(pcIn2),
      .programCounterWriteEnable(pcWe2), .fetchRequest(fetchReq2), .fetchReady(1'b1),
      .instructionLatchEnable(latchEn2), .executeDone(1'b0),
      .instructionIsJump(1'b0), .instructionIsBranch(1'b0), .branchTaken(1'b0),
      .targetAddress(32'h0), .haltRequest(1'b0), .resume(resume),
      .writebackEnable(wbEn2), .trapActive(trapAct2), .trapPc(trapPc2),
      .trapCause(trapCause2), .halted(halted2)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clock);
   endtask

   // Load a new PC while the sequencer idles in FETCH (fetchReady low).
   task automatic load_pc(input logic [31:0] v);
      ovr = 1'b1; ovr_val = v;
      step();
      ovr = 1'b0;
   endtask

   // One instruction starting from a FETCH cycle; checks the outcome state.
   task automatic run_instr(input logic ld, input logic [31:0] ld_pc, input int fwait,
                            input int ewait, input logic j, input logic b, input logic t,
                            input logic [31:0] tg, input logic h);
      logic [31:0] ipc, exp_pc;
      logic        tk;
      if (ld) load_pc(ld_pc);
      ipc = pc;
      chk1("fetch_req", fetchReq, 1'b1);
      for (int i = 0; i < fwait; i++) begin
         resume = 1'($urandom_range(0, 1));
         step();
         chk1("fetch_wait_latch", latchEn, 1'b0);
      end
      resume = 1'b0;
      fetchReady = 1'b1;
      #1 chk1("latch_en", latchEn, 1'b1);
      step();
      fetchReady = 1'b0;
      for (int i = 0; i < ewait; i++) begin
         step();
         chk1("exec_wait_we", pcWe, 1'b0);
      end
      executeDone = 1'b1; isJump = j; isBranch = b; brTaken = t; target = tg; haltReq = h;
      step();
      executeDone = 1'b0; isJump = 1'b0; isBranch = 1'b0; brTaken = 1'b0; haltReq = 1'b0;
      tk = j | (b & t);
      exp_pc = tk ? tg : ipc + 32'd4;
      if (tk && (tg[1:0] != 2'b00)) begin
         exp_cause = 2'b10; exp_tpc = ipc;
         chk1("tgt_trap_active", trapAct, 1'b1);
         chk1("tgt_trap_we", pcWe, 1'b1);
         chk1("tgt_trap_no_wb", wbEn, 1'b0);
         chk32("tgt_trap_pcin", pcIn, TV1);
         chk32("tgt_trap_cause", 32'(trapCause), 32'(exp_cause));
         chk32("tgt_trap_pc", trapPc, exp_tpc);
      end else if (h) begin
         chk1("halt_flag", halted, 1'b1);
         chk1("halt_no_we", pcWe, 1'b0);
         chk1("halt_no_wb", wbEn, 1'b0);
         repeat ($urandom_range(1, 3)) begin
            step();
            chk1("halt_stays", halted, 1'b1);
         end
         resume = 1'b1;
         step();
         resume = 1'b0;
         chk1("resume_wb", wbEn, 1'b1);
         chk1("resume_we", pcWe, 1'b1);
         chk1("resume_unhalt", halted, 1'b0);
         chk32("resume_pcin", pcIn, exp_pc);
      end else begin
         chk1("wb_en", wbEn, 1'b1);
         chk1("wb_we", pcWe, 1'b1);
         chk1("wb_no_trap", trapAct, 1'b0);
         chk32("wb_pcin", pcIn, exp_pc);
         chk32("wb_cause_held", 32'(trapCause), 32'(exp_cause));
         chk32("wb_trappc_held", trapPc, exp_tpc);
      end
      step();
   endtask

   // Misaligned fetch, expected to trap with cause 01 (double-fault arm clear).
   task automatic fetch_mis(input logic [31:0] v);
      load_pc(v);
      chk1("mis_no_fetch", fetchReq, 1'b0);
      step();
      exp_cause = 2'b01; exp_tpc = v;
      chk1("mis_trap_active", trapAct, 1'b1);
      chk1("mis_trap_we", pcWe, 1'b1);
      chk32("mis_trap_pcin", pcIn, TV1);
      chk32("mis_trap_cause", 32'(trapCause), 32'(exp_cause));
      chk32("mis_trap_pc", trapPc, exp_tpc);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r, lp;
      logic        j, b;
      reset = 1'b0; fetchReady = 1'b0; executeDone = 1'b0; isJump = 1'b0; isBranch = 1'b0;
      brTaken = 1'b0; target = '0; haltReq = 1'b0; resume = 1'b0; ovr = 1'b1; ovr_val = '0;
      exp_cause = 2'b00; exp_tpc = '0;
      step(); step();
      chk32("rst_pcin", pcIn, 32'h0);
      chk1("rst_we", pcWe, 1'b0);
      chk1("rst_wb", wbEn, 1'b0);
      chk1("rst_fetch", fetchReq, 1'b0);
      chk1("rst_halted", halted, 1'b0);
      chk32("rst_cause", 32'(trapCause), 32'h0);
      chk32("rst_trappc", trapPc, 32'h0);

      // Zero-wait sequential flow straight out of reset.
      reset = 1'b1; ovr = 1'b0; fetchReady = 1'b1; executeDone = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         step();
         chk1("seq_wb_cadence", wbEn, (k % 3) == 0);
         chk1("seq_we_cadence", pcWe, (k % 3) == 0);
         if ((k % 3) == 0) chk32("seq_pcin", pcIn, 32'(4 * (k / 3)));
         if (k == 2) begin
            chk1("dut2_trap", trapAct2, 1'b1);
            chk32("dut2_cause1", 32'(trapCause2), 32'h1);
            chk32("dut2_trappc", trapPc2, 32'h0000_000E);
         end
         if (k == 4) begin
            chk1("dut2_halted", halted2, 1'b1);
            chk32("dut2_cause3", 32'(trapCause2), 32'h3);
         end
      end
      fetchReady = 1'b0; executeDone = 1'b0;
      step();

      run_instr(1'b1, 32'h0000_0100, 0, 0, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b0);
      run_instr(1'b1, 32'h0000_0100, 1, 2, 1'b0, 1'b1, 1'b0, 32'h0000_0040, 1'b0);
      run_instr(1'b1, 32'hFFFF_FFFC, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      run_instr(1'b1, 32'h0000_0200, 0, 0, 1'b1, 1'b0, 1'b0, 32'h0000_0302, 1'b0);
      run_instr(1'b0, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      fetch_mis(32'h0000_000E);
      run_instr(1'b0, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      run_instr(1'b1, 32'h0000_0020, 0, 1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

      for (int n = 0; n < 40; n++) begin
         lp = $urandom() & 32'hFFFF_FFFC;
         r  = $urandom();
         if ($urandom_range(0, 7) != 0) r = r & 32'hFFFF_FFFC;
         j  = ($urandom_range(0, 3) == 0);
         b  = !j && ($urandom_range(0, 1) == 1);
         run_instr(1'($urandom_range(0, 1)), lp, $urandom_range(0, 3), $urandom_range(0, 3),
                   j, b, 1'($urandom_range(0, 1)), r, ($urandom_range(0, 7) == 0));
      end

      chk1("dut2_still_halted", halted2, 1'b1);
      chk32("dut2_still_cause3", 32'(trapCause2), 32'h3);

      // Reset asserted while waiting in EXECUTE.
      fetchReady = 1'b1;
      step();
      fetchReady = 1'b0;
      step();
      reset = 1'b0;
      #1;
      chk1("midrst_we", pcWe, 1'b0);
      chk1("midrst_wb", wbEn, 1'b0);
      chk1("midrst_trap", trapAct, 1'b0);
      chk1("midrst_fetch", fetchReq, 1'b0);
      chk32("midrst_pcin", pcIn, 32'h0);
      chk32("midrst_cause", 32'(trapCause), 32'h0);
      chk32("midrst_trappc", trapPc, 32'h0);
      chk1("midrst_dut2_halted", halted2, 1'b0);
      chk32("midrst_dut2_cause", 32'(trapCause2), 32'h0);
      step();
      reset = 1'b1;
      exp_cause = 2'b00; exp_tpc = '0;
      step();
      run_instr(1'b1, 32'h0000_0400, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
